// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron training data path.
// Sample fields are two's complement and are carried verbatim end to end.
package neuron_pkg;

  localparam int X_W = 7;
  localparam int T_W = 2;

  typedef struct packed {
    logic signed [X_W-1:0] x1;
    logic signed [X_W-1:0] x2;
    logic signed [T_W-1:0] t;
  } sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PRESENT,
    ST_HALT
  } feeder_state_e;

endpackage

// File: rtl/sample_mem.sv
// Training-set storage: one shared address, synchronous write, registered read.
// The read register is cleared by reset so the feeder outputs start at zero,
// and it only updates on a read, so it holds the last sample between reads.
module sample_mem
  import neuron_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  sample_t           wdata,
  output sample_t           rdata
);

  sample_t r_mem [DEPTH];
  sample_t r_rdata;

  // Store a sample; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Registered read port that keeps its value until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sample_feeder.sv
// Data-source end of the neuron training handshake. Samples are loaded while
// idle, then served one per neuron request with a one-cycle data_ready pulse,
// wrapping over the set each epoch until the neuron reports done.
// Optional build macro FEEDER_EPOCH_LIMIT_EN adds an epoch counter that halts
// streaming once MAX_EPOCHS epochs have been delivered.
module sample_feeder
  import neuron_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 9,
  parameter int MAX_EPOCHS = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic signed [X_W-1:0] load_x1,
  input  logic signed [X_W-1:0] load_x2,
  input  logic signed [T_W-1:0] load_t,
  input  logic                  load_last,
  input  logic                  start,
  input  logic                  req,
  input  logic                  done_in,
  output logic signed [X_W-1:0] x1_out,
  output logic signed [X_W-1:0] x2_out,
  output logic signed [T_W-1:0] t_out,
  output logic                  data_ready,
  output logic                  epoch_wrap,
  output logic [ADDR_W:0]       n_count,
  output logic                  load_ovf,
  output logic                  busy
`ifdef FEEDER_EPOCH_LIMIT_EN
  ,
  output logic [15:0]           epoch_count,
  output logic                  limit_hit
`endif
);

  localparam logic [ADDR_W:0]   FULL_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE_C = ADDR_W'(1);

  feeder_state_e     r_state;
  feeder_state_e     w_nextState;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W:0]   r_nCount;
  logic              r_loadOvf;
  logic              w_memRe;
  logic              w_memWe;
  logic              w_restart;
  logic              w_isLast;
  logic [ADDR_W-1:0] w_memAddr;
  sample_t           w_wdata;
  sample_t           w_rdata;

  // The last sample of the set is the one whose index is n_count-1.
  assign w_isLast = ({1'b0, r_index} == (r_nCount - ONE_C));

`ifdef FEEDER_EPOCH_LIMIT_EN
  localparam logic [15:0] EPOCH_LIMIT_C = 16'(MAX_EPOCHS);
  logic [15:0] r_epochCount;
  logic        r_limitHit;
  logic        w_limitReached;
  logic        w_haltLimit;

  // True when the wrap now being presented completes the final allowed epoch.
  assign w_limitReached = (r_epochCount + 16'd1) >= EPOCH_LIMIT_C;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    w_nextState = r_state;
    w_memRe     = 1'b0;
    w_restart   = 1'b0;
`ifdef FEEDER_EPOCH_LIMIT_EN
    w_haltLimit = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start && (r_nCount != '0)) begin
          w_restart   = 1'b1;
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_in) begin
          w_nextState = ST_HALT;
        end else if (req) begin
          w_memRe     = 1'b1;
          w_nextState = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        w_nextState = ST_WAIT;
        if (done_in) begin
          w_nextState = ST_HALT;
        end
`ifdef FEEDER_EPOCH_LIMIT_EN
        if (w_isLast && w_limitReached) begin
          w_nextState = ST_HALT;
          w_haltLimit = 1'b1;
        end
`endif
      end
      ST_HALT: begin
        if (start && (r_nCount != '0)) begin
          w_restart   = 1'b1;
          w_nextState = ST_WAIT;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Loading only happens while idle; the pointer may reach DEPTH to flag overflow.
  assign w_memWe   = !rst && (r_state == ST_IDLE) && load_en && (r_ptr < FULL_C);
  assign w_memAddr = (r_state == ST_IDLE) ? r_ptr[ADDR_W-1:0] : r_index;
  assign w_wdata   = '{x1: load_x1, x2: load_x2, t: load_t};

  // Load pointer, sample count, overflow flag and read index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_index   <= '0;
      r_nCount  <= '0;
      r_loadOvf <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && load_en) begin
        if (r_ptr < FULL_C) begin
          r_ptr <= r_ptr + ONE_C;
          if (load_last) begin
            r_nCount <= r_ptr + ONE_C;
          end
        end else begin
          r_loadOvf <= 1'b1;
          if (load_last) begin
            r_nCount <= FULL_C;
          end
        end
      end
      if (w_restart) begin
        r_index <= '0;
      end else if (r_state == ST_PRESENT) begin
        r_index <= w_isLast ? '0 : (r_index + IDX_ONE_C);
      end
    end
  end

`ifdef FEEDER_EPOCH_LIMIT_EN
  // Epoch counter and sticky limit flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_epochCount <= '0;
      r_limitHit   <= 1'b0;
    end else begin
      if (epoch_wrap && (r_epochCount != 16'hFFFF)) begin
        r_epochCount <= r_epochCount + 16'd1;
      end
      if (w_haltLimit) begin
        r_limitHit <= 1'b1;
      end
    end
  end

  assign epoch_count = r_epochCount;
  assign limit_hit   = r_limitHit;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_EPOCHS > 0);
`endif

  sample_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (w_memWe),
    .re   (w_memRe),
    .addr (w_memAddr),
    .wdata(w_wdata),
    .rdata(w_rdata)
  );

  assign x1_out     = w_rdata.x1;
  assign x2_out     = w_rdata.x2;
  assign t_out      = w_rdata.t;
  assign data_ready = (r_state == ST_PRESENT);
  assign epoch_wrap = (r_state == ST_PRESENT) && w_isLast;
  assign busy       = (r_state == ST_WAIT) || (r_state == ST_PRESENT);
  assign n_count    = r_nCount;
  assign load_ovf   = r_loadOvf;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder with a small memory (DEPTH 8) so the
// overflow boundary is reached quickly. The epoch-limit scenario is only
// built when FEEDER_EPOCH_LIMIT_EN is defined.
module tb_sample_feeder;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_en = 1'b0;
  logic signed [6:0] load_x1 = '0;
  logic signed [6:0] load_x2 = '0;
  logic signed [1:0] load_t = '0;
  logic              load_last = 1'b0;
  logic              start = 1'b0;
  logic              req = 1'b0;
  logic              done_in = 1'b0;
  logic signed [6:0] x1_out;
  logic signed [6:0] x2_out;
  logic signed [1:0] t_out;
  logic              data_ready;
  logic              epoch_wrap;
  logic [3:0]        n_count;
  logic              load_ovf;
  logic              busy;
`ifdef FEEDER_EPOCH_LIMIT_EN
  logic [15:0]       epoch_count;
  logic              limit_hit;
`endif

  int nChecks = 0;
  int nPass = 0;

  logic signed [6:0] sx1 [3];
  logic signed [6:0] sx2 [3];
  logic signed [1:0] st  [3];

  sample_feeder #(
    .DEPTH(8),
    .ADDR_W(3),
    .MAX_EPOCHS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_en(load_en),
    .load_x1(load_x1),
    .load_x2(load_x2),
    .load_t(load_t),
    .load_last(load_last),
    .start(start),
    .req(req),
    .done_in(done_in),
    .x1_out(x1_out),
    .x2_out(x2_out),
    .t_out(t_out),
    .data_ready(data_ready),
    .epoch_wrap(epoch_wrap),
    .n_count(n_count),
    .load_ovf(load_ovf),
    .busy(busy)
`ifdef FEEDER_EPOCH_LIMIT_EN
    ,
    .epoch_count(epoch_count),
    .limit_hit(limit_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic signed [6:0] x1, input logic signed [6:0] x2,
                               input logic signed [1:0] t, input logic last);
    load_en   = 1'b1;
    load_x1   = x1;
    load_x2   = x2;
    load_t    = t;
    load_last = last;
    tick();
    load_en   = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nChecks++; if (data_ready !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", data_ready); else nPass++;
    nChecks++; if (epoch_wrap !== 1'b0) $display("[TB] FAIL reset_wrap got %b want 0", epoch_wrap); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else nPass++;
    nChecks++; if (n_count !== 4'd0) $display("[TB] FAIL reset_ncount got %0d want 0", n_count); else nPass++;
    nChecks++; if (load_ovf !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", load_ovf); else nPass++;
    nChecks++; if ({x1_out, x2_out, t_out} !== 16'h0) $display("[TB] FAIL reset_data got %h want 0", {x1_out, x2_out, t_out}); else nPass++;
  endtask

  task automatic test_load_stream();
    int exp;
    int prev;
    for (int i = 0; i < 3; i++) applyStimulus(sx1[i], sx2[i], st[i], (i == 2));
    nChecks++; if (n_count !== 4'd3) $display("[TB] FAIL load_ncount got %0d want 3", n_count); else nPass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    nChecks++; if (busy !== 1'b1) $display("[TB] FAIL start_busy got %b want 1", busy); else nPass++;
    req = 1'b1;
    exp = 0;
    prev = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c % 2 == 0) begin
        nChecks++; if (data_ready !== 1'b1) $display("[TB] FAIL stream_ready c=%0d got %b want 1", c, data_ready); else nPass++;
        nChecks++; if (x1_out !== sx1[exp] || x2_out !== sx2[exp] || t_out !== st[exp])
          $display("[TB] FAIL stream_data c=%0d got %0d,%0d,%0d want %0d,%0d,%0d", c, x1_out, x2_out, t_out, sx1[exp], sx2[exp], st[exp]); else nPass++;
        nChecks++; if (epoch_wrap !== (exp == 2)) $display("[TB] FAIL stream_wrap c=%0d got %b want %b", c, epoch_wrap, (exp == 2)); else nPass++;
        prev = exp;
        exp = (exp + 1) % 3;
      end else begin
        nChecks++; if (data_ready !== 1'b0 || epoch_wrap !== 1'b0) $display("[TB] FAIL stream_gap c=%0d got %b%b want 00", c, data_ready, epoch_wrap); else nPass++;
        nChecks++; if (x1_out !== sx1[prev]) $display("[TB] FAIL stream_hold c=%0d got %0d want %0d", c, x1_out, sx1[prev]); else nPass++;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_done();
    done_in = 1'b1;
    req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      nChecks++; if (data_ready !== 1'b0) $display("[TB] FAIL done_ready c=%0d got %b want 0", c, data_ready); else nPass++;
      nChecks++; if (busy !== 1'b0) $display("[TB] FAIL done_busy c=%0d got %b want 0", c, busy); else nPass++;
      nChecks++; if (x1_out !== 7'sd5 || t_out !== 2'sd1) $display("[TB] FAIL done_hold c=%0d got %0d,%0d want 5,1", c, x1_out, t_out); else nPass++;
    end
    done_in = 1'b0;
    req = 1'b0;
    tick();
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL halt_stay got busy %b want 0", busy); else nPass++;
  endtask

  task automatic test_latency();
    start = 1'b1;
    tick();
    start = 1'b0;
    nChecks++; if (busy !== 1'b1 || data_ready !== 1'b0) $display("[TB] FAIL restart got busy %b ready %b want 1 0", busy, data_ready); else nPass++;
    req = 1'b1;
    tick();
    req = 1'b0;
    nChecks++; if (data_ready !== 1'b1) $display("[TB] FAIL lat_ready got %b want 1", data_ready); else nPass++;
    nChecks++; if (x1_out !== sx1[0] || x2_out !== sx2[0]) $display("[TB] FAIL lat_data got %0d,%0d want %0d,%0d", x1_out, x2_out, sx1[0], sx2[0]); else nPass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      nChecks++; if (data_ready !== 1'b0) $display("[TB] FAIL lat_nopulse c=%0d got %b want 0", c, data_ready); else nPass++;
    end
  endtask

  task automatic test_reset_mid();
    req = 1'b1;
    tick();
    nChecks++; if (x1_out !== sx1[1]) $display("[TB] FAIL mid_sample got %0d want %0d", x1_out, sx1[1]); else nPass++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 1'b0;
    nChecks++; if ({x1_out, x2_out, t_out} !== 16'h0) $display("[TB] FAIL mid_data got %h want 0", {x1_out, x2_out, t_out}); else nPass++;
    nChecks++; if ({data_ready, epoch_wrap, busy, load_ovf} !== 4'b0) $display("[TB] FAIL mid_flags got %b want 0000", {data_ready, epoch_wrap, busy, load_ovf}); else nPass++;
    nChecks++; if (n_count !== 4'd0) $display("[TB] FAIL mid_ncount got %0d want 0", n_count); else nPass++;
  endtask

  task automatic test_start_empty();
    start = 1'b1;
    tick();
    start = 1'b0;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL empty_start got busy %b want 0", busy); else nPass++;
    req = 1'b1;
    tick();
    req = 1'b0;
    nChecks++; if (data_ready !== 1'b0) $display("[TB] FAIL empty_ready got %b want 0", data_ready); else nPass++;
  endtask

  task automatic test_single();
    applyStimulus(-7'sd7, 7'sd2, -2'sd1, 1'b1);
    nChecks++; if (n_count !== 4'd1) $display("[TB] FAIL single_ncount got %0d want 1", n_count); else nPass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c % 2 == 0) begin
        nChecks++; if (data_ready !== 1'b1 || epoch_wrap !== 1'b1) $display("[TB] FAIL single_pulse c=%0d got %b%b want 11", c, data_ready, epoch_wrap); else nPass++;
        nChecks++; if (x1_out !== -7'sd7 || x2_out !== 7'sd2 || t_out !== -2'sd1) $display("[TB] FAIL single_data c=%0d got %0d,%0d,%0d want -7,2,-1", c, x1_out, x2_out, t_out); else nPass++;
      end else begin
        nChecks++; if (data_ready !== 1'b0 || epoch_wrap !== 1'b0) $display("[TB] FAIL single_gap c=%0d got %b%b want 00", c, data_ready, epoch_wrap); else nPass++;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_overflow();
    logic signed [6:0] v1;
    int k;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v1 = 7'(i + 1);
      applyStimulus(v1, -v1, 2'sd1, 1'b0);
    end
    nChecks++; if (load_ovf !== 1'b0 || n_count !== 4'd0) $display("[TB] FAIL full_noovf got ovf %b n %0d want 0 0", load_ovf, n_count); else nPass++;
    applyStimulus(7'sd20, 7'sd20, -2'sd1, 1'b1);
    nChecks++; if (load_ovf !== 1'b1) $display("[TB] FAIL ovf_flag got %b want 1", load_ovf); else nPass++;
    nChecks++; if (n_count !== 4'd8) $display("[TB] FAIL ovf_ncount got %0d want 8", n_count); else nPass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    req = 1'b1;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c % 2 == 0) begin
        v1 = 7'(k + 1);
        nChecks++; if (x1_out !== v1 || x2_out !== -v1 || t_out !== 2'sd1) $display("[TB] FAIL ovf_data k=%0d got %0d,%0d,%0d want %0d,%0d,1", k, x1_out, x2_out, t_out, v1, -v1); else nPass++;
        nChecks++; if (epoch_wrap !== (k == 7)) $display("[TB] FAIL ovf_wrap k=%0d got %b want %b", k, epoch_wrap, (k == 7)); else nPass++;
        k++;
      end
    end
    req = 1'b0;
    nChecks++; if (load_ovf !== 1'b1) $display("[TB] FAIL ovf_sticky got %b want 1", load_ovf); else nPass++;
  endtask

`ifdef FEEDER_EPOCH_LIMIT_EN
  task automatic test_epoch_limit();
    int pulses;
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(sx1[i], sx2[i], st[i], (i == 2));
    start = 1'b1;
    tick();
    start = 1'b0;
    req = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (data_ready === 1'b1) pulses++;
    end
    req = 1'b0;
    nChecks++; if (pulses != 6) $display("[TB] FAIL limit_pulses got %0d want 6", pulses); else nPass++;
    nChecks++; if (epoch_count !== 16'd2) $display("[TB] FAIL limit_count got %0d want 2", epoch_count); else nPass++;
    nChecks++; if (limit_hit !== 1'b1) $display("[TB] FAIL limit_hit got %b want 1", limit_hit); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL limit_halt got busy %b want 0", busy); else nPass++;
  endtask
`endif

  initial begin
    sx1[0] = 7'sd5;  sx2[0] = -7'sd3; st[0] = 2'sd1;
    sx1[1] = -7'sd7; sx2[1] = 7'sd2;  st[1] = -2'sd1;
    sx1[2] = 7'sd0;  sx2[2] = 7'sd63; st[2] = 2'sd1;
    test_reset();
    test_load_stream();
    test_done();
    test_latency();
    test_reset_mid();
    test_start_empty();
    test_single();
    test_overflow();
`ifdef FEEDER_EPOCH_LIMIT_EN
    test_epoch_limit();
`endif
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
Name: sample_feeder

Overview:
- Synthesizable data-source end of the neuron training handshake.
- Holds a training set of (x1, x2, t) samples in on-chip memory.
- Serves one sample per neuron request, with a one-cycle data_ready pulse, wrapping over the set each epoch until the neuron reports done.
- Replaces bench-driven stimulus so training can run in hardware.

Parameters:
- DEPTH, 512, max samples stored.
- ADDR_W, 9, index width; must satisfy 2**ADDR_W >= DEPTH.
- MAX_EPOCHS, 1000, epoch limit; used only with FEEDER_EPOCH_LIMIT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write one sample at the load pointer.
- load_x1  in  7  signed x1 of loaded sample.
- load_x2  in  7  signed x2 of loaded sample.
- load_t  in  2  signed target (+1/-1) of loaded sample.
- load_last  in  1  qualifies load_en: this sample is the final one.
- start  in  1  begin streaming (pulse).
- req  in  1  neuron requestFlag (level).
- done_in  in  1  neuron training complete.
- x1_out  out  7  signed sample x1.
- x2_out  out  7  signed sample x2.
- t_out  out  2  signed sample target.
- data_ready  out  1  one-cycle pulse; outputs are valid this cycle.
- epoch_wrap  out  1  one-cycle pulse, coincident with data_ready, for the last sample of an epoch.
- n_count  out  ADDR_W+1  number of loaded samples.
- load_ovf  out  1  sticky: load attempted with a full memory.
- busy  out  1  high in WAIT and PRESENT.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - State IDLE; load pointer 0; read index 0; n_count 0.
  - Memory contents are not cleared.
- Reset mid-operation aborts streaming. The set must be reloaded before the next start.
- States: IDLE, WAIT, PRESENT, HALT.
- IDLE (loading):
  - load_en with pointer < DEPTH: write at the pointer, then pointer+1.
  - load_en with load_last: n_count <= pointer+1.
  - load_en with pointer == DEPTH: write ignored, load_ovf <= 1. If load_last is also high, n_count <= DEPTH.
  - start with n_count == 0: ignored.
  - start with n_count > 0: index <= 0, go to WAIT.
  - load_en in any other state: ignored, no flag.
- WAIT:
  - done_in (checked first): go to HALT.
  - Else req == 1: issue a registered memory read of index, go to PRESENT.
- PRESENT:
  - data_ready = 1; x1_out/x2_out/t_out = sample[index].
  - Latency: req sampled in cycle k gives data_ready in cycle k+1.
  - If index == n_count-1: epoch_wrap = 1 and index <= 0. Otherwise index+1.
  - Always return to WAIT. Minimum spacing between pulses is 2 cycles.
  - A req still high in the following WAIT cycle is a new request.
  - done_in during PRESENT: the sample is still delivered, then go to HALT.
- HALT:
  - Outputs hold their last sample values; data_ready = 0.
  - Leaves only via rst, or start (which restarts at index 0 with the loaded set).
- Outputs x1_out/x2_out/t_out hold their value between pulses.
- Samples are stored and output verbatim: two's complement, no sign extension or arithmetic.

Optional Feature:
- Macro: FEEDER_EPOCH_LIMIT_EN.
- When defined:
  - Adds output epoch_count [15:0], reset 0, incremented on every epoch_wrap.
  - When epoch_count reaches MAX_EPOCHS, the state goes to HALT after that PRESENT, regardless of done_in.
  - Adds output limit_hit (sticky, reset 0), set at that transition.
- When undefined: no counter and no ports. Streaming continues until done_in.

Decomposition:
- Package neuron_pkg:
  - Constants X_W = 7, T_W = 2.
  - typedef sample_t, a packed struct {x1, x2, t}.
  - Feeder state enum.
- Sub-module sample_mem: single-port write, registered-read RAM of DEPTH x sample_t. The FSM, pointers and flags live in sample_feeder.

Test Plan:
- Load set: load 3 samples (5,-3,+1), (-7,2,-1), (0,63,+1) with last on the third; start; hold req high → n_count = 3; data_ready every 2nd cycle with the samples in order; epoch_wrap on the third; the fourth pulse is sample 0 again.
- Latency: req high for 1 cycle at cycle k → data_ready only at k+1, outputs = sample 0; no further pulse.
- done_in: assert done_in the same cycle req is sampled → no pulse; HALT; busy = 0; outputs hold.
- Edge cases:
  - start with n_count = 0 → stays IDLE.
  - Load DEPTH+1 samples → load_ovf = 1, n_count = DEPTH.
  - rst mid-stream → all outputs 0, IDLE.
- Epoch limit: FEEDER_EPOCH_LIMIT_EN with MAX_EPOCHS = 2, 3-sample set, req held → exactly 6 pulses; epoch_count = 2; limit_hit = 1; HALT.
- Single sample: n_count = 1 → every pulse has epoch_wrap = 1 and the same sample.
